mem_burst_ctrl: RTL and testbench
=================================

// Module: mem_burst_ctrl
// PURPOSE
//   Burst sequencer directly upstream of the single-port memory (8x128, sync rd/wr,
//   1-cycle registered read). Accepts burst commands, drives the memory port one
//   beat per cycle with incrementing, wrapping addresses. Streams write data in and
//   read data out. Sole master of the memory's addr/wdata/wr_en/rd_en.
// PARAMETERS
//   WIDTH      8  data width; equals memory WIDTH
//   ADD_WIDTH  7  address width; equals memory ADD_WIDTH (depth = 2**ADD_WIDTH)
//   LEN_WIDTH  8  burst length field width; cmd_len = beats-1 (max 2**LEN_WIDTH beats)
// PORTS
//   clk        in   1          clock, all logic on posedge
//   rst        in   1          synchronous active-high reset
//   cmd_valid  in   1          command offered
//   cmd_ready  out  1          command accepted when cmd_valid & cmd_ready
//   cmd_write  in   1          1 = write burst, 0 = read burst
//   cmd_addr   in   ADD_WIDTH  first beat address
//   cmd_len    in   LEN_WIDTH  beats minus one
//   wr_valid   in   1          write beat offered
//   wr_ready   out  1          write beat consumed when wr_valid & wr_ready
//   wr_data    in   WIDTH      write beat data
//   rd_valid   out  1          read beat valid (no backpressure; sink must take it)
//   rd_data    out  WIDTH      read beat data
//   rd_last    out  1          qualifies final beat of a read burst
//   busy       out  1          burst active or read beat in flight
//   mem_addr   out  ADD_WIDTH  to memory addr
//   mem_wdata  out  WIDTH      to memory wdata
//   mem_wr_en  out  1          to memory wr_en
//   mem_rd_en  out  1          to memory rd_en
//   mem_rdata  in   WIDTH      from memory rdata
// BEHAVIOUR
//   - After any posedge with rst=1: state IDLE, rd_valid=0, rd_last=0, busy=0,
//     cmd_ready=1, wr_ready=0. mem_wr_en/mem_rd_en forced 0 while rst=1.
//   - Reset mid-burst: burst abandoned, no further beats, in-flight read beat dropped.
//   - FSM: IDLE -> WR (accepted cmd_write=1) | RD (accepted cmd_write=0);
//     WR/RD -> IDLE after final beat issued. cmd_ready = (state==IDLE) only.
//   - Accept cycle loads cur_addr=cmd_addr, beats_left=cmd_len; no memory access that cycle.
//   - WR: wr_ready=1; each cycle wr_valid=1 -> mem_wr_en=1, mem_addr=cur_addr,
//     mem_wdata=wr_data, cur_addr++, beats_left--. wr_valid=0 -> stall, no access.
//     Zero-bubble: back-to-back wr_valid gives one write per cycle.
//   - RD: mem_rd_en=1, mem_addr=cur_addr every cycle, no stalls; rd_valid registered
//     from mem_rd_en (1-cycle latency); rd_data = mem_rdata; rd_last = registered
//     (issuing final beat).
//   - mem_* outputs combinational from state/cur_addr; mem_addr=cur_addr when idle.
//   - cur_addr increments modulo 2**ADD_WIDTH: 127 -> 0 wraps silently.
//   - cmd_len=0: single beat. cmd_len = 2**LEN_WIDTH-1: 256 beats; exceeding depth
//     overwrites/re-reads wrapped locations.
//   - Final read beat's rd_valid appears in first IDLE cycle; a new command may be
//     accepted that same cycle (no conflict, its first access is one cycle later).
//   - busy = (state!=IDLE) | rd_valid.
//   - cmd_* ignored outside IDLE; wr_valid ignored outside WR.
// CONFIGURATION
//   MEM_BURST_STATS_EN defined: adds out ports stat_wr_beats[15:0], stat_rd_beats[15:0]
//     counting mem_wr_en / rd_valid beats; saturate at 16'hFFFF; cleared by rst.
//   Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   1 rst 2 cycles mid-RD burst -> rd_valid=0 next cycle, cmd_ready=1, no mem_*_en.
//   2 write addr=0x10 len=3 data A0..A3, wr_valid continuous -> 4 writes @0x10..0x13
//     on consecutive cycles; then read same -> rd_data A0..A3, rd_last on A3.
//   3 write len=1 with wr_valid gap of 3 cycles between beats -> exactly 2 writes,
//     no access during gap, wr_ready held 1.
//   4 write addr=0x7E len=3 (11,22,33,44) -> locations 7E,7F,00,01; read back wraps same.
//   5 read len=0 addr=5 then new cmd on rd_valid cycle -> single beat rd_last=1,
//     second command accepted that cycle, first access next cycle.
//   6 MEM_BURST_STATS_EN: preload counters via 65540 write beats -> stat_wr_beats=FFFF.

Source files
------------

// File: rtl/mem_burst_ctrl_if.sv
// Command / write-stream / read-stream / memory-port bundle for mem_burst_ctrl.
// slave = the burst controller, master = the command source, stream endpoints and memory.
interface mem_burst_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int ADD_WIDTH = 7,
  parameter int LEN_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADD_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_valid;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_last;
  logic                 busy;
  logic [ADD_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 mem_wr_en;
  logic                 mem_rd_en;
  logic [WIDTH-1:0]     mem_rdata;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
           mem_addr, mem_wdata, mem_wr_en, mem_rd_en
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
           mem_addr, mem_wdata, mem_wr_en, mem_rd_en
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of a single-port sync memory: one beat per cycle, wrapping addresses.
// Optional beat counters are compiled in when MEM_BURST_STATS_EN is defined.
module mem_burst_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ADD_WIDTH = 7,
  parameter int LEN_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  mem_burst_ctrl_if.slave bus
`ifdef MEM_BURST_STATS_EN
  ,
  output logic [15:0] stat_wr_beats,
  output logic [15:0] stat_rd_beats
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [ADD_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 rd_valid_q;
  logic                 rd_last_q;
  logic                 issue_last;
  logic                 cmd_accept;
  logic                 beat_issue;

  // Next state, handshakes and the combinational memory port.
  always_comb begin
    state_next     = state;
    bus.cmd_ready  = 1'b0;
    bus.wr_ready   = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_rd_en  = 1'b0;
    bus.mem_addr   = cur_addr;
    bus.mem_wdata  = {WIDTH{1'b0}};
    issue_last     = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          state_next = bus.cmd_write ? WR : RD;
        end else begin
          state_next = IDLE;
        end
      end
      WR: begin
        bus.wr_ready  = 1'b1;
        bus.mem_wdata = bus.wr_data;
        if (bus.wr_valid) begin
          bus.mem_wr_en = 1'b1;
          if (beats_left == {LEN_WIDTH{1'b0}}) begin
            state_next = IDLE;
          end else begin
            state_next = WR;
          end
        end else begin
          state_next = WR;
        end
      end
      RD: begin
        bus.mem_rd_en = 1'b1;
        if (beats_left == {LEN_WIDTH{1'b0}}) begin
          state_next = IDLE;
          issue_last = 1'b1;
        end else begin
          state_next = RD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Memory strobes must never fire while reset is held, whatever state we are leaving.
    if (rst) begin
      bus.mem_wr_en = 1'b0;
      bus.mem_rd_en = 1'b0;
      issue_last    = 1'b0;
    end else begin
      issue_last    = issue_last;
    end
  end

  assign cmd_accept = bus.cmd_ready & bus.cmd_valid;
  assign beat_issue = bus.mem_wr_en | bus.mem_rd_en;

  // State, burst address/count and the one-cycle read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= {ADD_WIDTH{1'b0}};
      beats_left <= {LEN_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state      <= state_next;
      rd_valid_q <= bus.mem_rd_en;
      rd_last_q  <= issue_last;
      if (cmd_accept) begin
        cur_addr   <= bus.cmd_addr;
        beats_left <= bus.cmd_len;
      end else if (beat_issue) begin
        cur_addr   <= cur_addr + ADD_WIDTH'(1);
        beats_left <= beats_left - LEN_WIDTH'(1);
      end else begin
        cur_addr   <= cur_addr;
        beats_left <= beats_left;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_data  = bus.mem_rdata;
  assign bus.busy     = (state != IDLE) | rd_valid_q;

`ifdef MEM_BURST_STATS_EN
  // Saturating beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_beats <= 16'h0000;
      stat_rd_beats <= 16'h0000;
    end else begin
      if (bus.mem_wr_en && (stat_wr_beats != 16'hFFFF)) begin
        stat_wr_beats <= stat_wr_beats + 16'h0001;
      end else begin
        stat_wr_beats <= stat_wr_beats;
      end
      if (rd_valid_q && (stat_rd_beats != 16'hFFFF)) begin
        stat_rd_beats <= stat_rd_beats + 16'h0001;
      end else begin
        stat_rd_beats <= stat_rd_beats;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl: reference memory array predicts every write and read beat.
module tb_mem_burst_ctrl;
  localparam int WIDTH     = 8;
  localparam int ADD_WIDTH = 7;
  localparam int LEN_WIDTH = 8;
  localparam int DEPTH     = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_ctrl_if #(.WIDTH(WIDTH), .ADD_WIDTH(ADD_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

`ifdef MEM_BURST_STATS_EN
  logic [15:0] stat_wr_beats;
  logic [15:0] stat_rd_beats;
`endif

  mem_burst_ctrl #(.WIDTH(WIDTH), .ADD_WIDTH(ADD_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef MEM_BURST_STATS_EN
    ,
    .stat_wr_beats(stat_wr_beats),
    .stat_rd_beats(stat_rd_beats)
`endif
  );

  // Memory the controller drives: sync write, 1-cycle registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  typedef struct { logic [6:0] addr; logic [7:0] data; } wr_exp_t;
  typedef struct { logic [7:0] data; logic last; } rd_exp_t;
  wr_exp_t wq[$];
  rd_exp_t rq[$];
  logic [7:0] ref_mem [DEPTH];
  int wr_model = 0;
  int rd_model = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and every read beat is matched against the scoreboard.
  always @(negedge clk) begin
    wr_exp_t w;
    rd_exp_t r;
    if (bus.mem_wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = wq.pop_front();
        chk("write_addr", 32'(bus.mem_addr), 32'(w.addr));
        chk("write_data", 32'(bus.mem_wdata), 32'(w.data));
      end
    end
    if (bus.rd_valid === 1'b1) begin
      if (rq.size() == 0) begin
        chk("unexpected_read", 32'd1, 32'd0);
      end else begin
        r = rq.pop_front();
        chk("read_data", 32'(bus.rd_data), 32'(r.data));
        chk("read_last", 32'(bus.rd_last), 32'(r.last));
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue_cmd(input logic wr, input logic [6:0] a, input logic [7:0] l);
    bit acc = 1'b0;
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = l;
    while (!acc && n < 1000) begin
      @(negedge clk); acc = bus.cmd_ready; @(posedge clk); #1; n++;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_burst(input logic [6:0] a, input logic [7:0] l, input int gap,
                             input logic [7:0] d[$]);
    bit acc;
    int n;
    logic [6:0] wa;
    issue_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_wr_ready", 32'(bus.wr_ready), 32'd1);
          chk("gap_no_write", 32'(bus.mem_wr_en), 32'd0);
          @(posedge clk); #1;
        end
      end
      wa = 7'((int'(a) + i) % DEPTH);
      bus.wr_valid = 1'b1; bus.wr_data = d[i];
      wq.push_back('{addr: wa, data: d[i]});
      ref_mem[wa] = d[i];
      if (wr_model < 65535) wr_model++;
      acc = 1'b0; n = 0;
      while (!acc && n < 100) begin
        @(negedge clk);
        acc = bus.wr_ready;
        if (acc) chk("beat_written_same_cycle", 32'(bus.mem_wr_en), 32'd1);
        @(posedge clk); #1; n++;
      end
      bus.wr_valid = 1'b0;
      if (!acc) chk("wr_beat_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic push_read(input logic [6:0] a, input logic [7:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      rq.push_back('{data: ref_mem[(int'(a) + i) % DEPTH], last: (i == int'(l))});
      if (rd_model < 65535) rd_model++;
    end
  endtask

  task automatic read_burst(input logic [6:0] a, input logic [7:0] l);
    push_read(a, l);
    issue_cmd(1'b0, a, l);
  endtask

  task automatic wait_idle();
    int n = 0;
    bit idle = 1'b0;
    while (!idle && n < 1000) begin
      @(negedge clk); idle = !bus.busy; @(posedge clk); #1; n++;
    end
    if (!idle) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_data(input int cnt, output logic [7:0] d[$]);
    d = {};
    for (int i = 0; i < cnt; i++) d.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    logic [6:0] ra;
    logic [7:0] rl;
    int gp;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 7'h00; bus.cmd_len = 8'h00;
    bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.mem_rdata = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_en", 32'({bus.mem_wr_en, bus.mem_rd_en}), 32'd0);
    @(posedge clk); #1;

    // Reset held two cycles in the middle of a read burst.
    read_burst(7'h40, 8'd20);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_mem_en", 32'({bus.mem_wr_en, bus.mem_rd_en}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_mid_no_mem_en2", 32'({bus.mem_wr_en, bus.mem_rd_en}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rq.delete();
    wr_model = 0; rd_model = 0;
    @(negedge clk);
    chk("post_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_no_mem_en", 32'({bus.mem_wr_en, bus.mem_rd_en}), 32'd0);
    @(posedge clk); #1;

    // Continuous 4-beat write then read back.
    d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    write_burst(7'h10, 8'd3, 0, d);
    read_burst(7'h10, 8'd3);
    wait_idle();

    // Two-beat write with a 3-cycle gap.
    d = '{8'h5A, 8'hC3};
    write_burst(7'h20, 8'd1, 3, d);
    read_burst(7'h20, 8'd1);
    wait_idle();

    // Address wrap at the top of memory.
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_burst(7'h7E, 8'd3, 0, d);
    read_burst(7'h7E, 8'd3);
    wait_idle();

    // Single-beat read; next command accepted on its rd_valid cycle.
    read_burst(7'h05, 8'd0);
    push_read(7'h7F, 8'd2);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 7'h7F; bus.cmd_len = 8'd2;
    @(negedge clk);
    chk("rd_cycle_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("b2b_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("b2b_no_access_accept", 32'(bus.mem_rd_en), 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_first_access", 32'(bus.mem_rd_en), 32'd1);
    chk("b2b_first_addr", 32'(bus.mem_addr), 32'h7F);
    @(posedge clk); #1;
    wait_idle();

    // Randomized mix of bursts, including lengths that exceed the depth.
    for (int t = 0; t < 40; t++) begin
      ra = 7'($urandom_range(0, 127));
      rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(120, 255)) : 8'($urandom_range(0, 12));
      gp = (rl > 8'd12) ? 0 : int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        rand_data(int'(rl) + 1, d);
        write_burst(ra, rl, gp, d);
      end else begin
        read_burst(ra, rl);
      end
    end
    wait_idle();

`ifdef MEM_BURST_STATS_EN
    chk("stat_wr_beats", 32'(stat_wr_beats), 32'(wr_model));
    chk("stat_rd_beats", 32'(stat_rd_beats), 32'(rd_model));
    for (int b = 0; b < 256; b++) begin
      rand_data(256, d);
      write_burst(7'($urandom_range(0, 127)), 8'd255, 0, d);
    end
    rand_data(4, d);
    write_burst(7'h00, 8'd3, 0, d);
    wait_idle();
    chk("stat_wr_saturated", 32'(stat_wr_beats), 32'hFFFF);
    chk("stat_wr_model", 32'(stat_wr_beats), 32'(wr_model));
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
